stack_controller: RTL and testbench

//  Multicycle control FSM for the 8-bit stack-machine datapath; sits directly upstream of it.

---
 rtl/stack_ctrl_pkg.sv | 57 +++++
 rtl/stack_ctrl_decode.sv | 68 ++++++
 rtl/stack_controller.sv | 103 ++++++++++
 tb/tb_stack_controller.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/stack_ctrl_pkg.sv
// Shared definitions for the stack-machine control FSM: opcodes, ALU functions,
// state encoding and the bit layout of the control bundle.
package stack_ctrl_pkg;

    localparam int OPCODE_W = 3;
    localparam int ALUOP_W  = 2;

    localparam logic [OPCODE_W-1:0] OP_ADD  = 3'b000;
    localparam logic [OPCODE_W-1:0] OP_SUB  = 3'b001;
    localparam logic [OPCODE_W-1:0] OP_AND  = 3'b010;
    localparam logic [OPCODE_W-1:0] OP_NOT  = 3'b011;
    localparam logic [OPCODE_W-1:0] OP_PUSH = 3'b100;
    localparam logic [OPCODE_W-1:0] OP_POP  = 3'b101;
    localparam logic [OPCODE_W-1:0] OP_JMP  = 3'b110;
    localparam logic [OPCODE_W-1:0] OP_JZ   = 3'b111;

    localparam logic [ALUOP_W-1:0] ALU_ADD = 2'b00;
    localparam logic [ALUOP_W-1:0] ALU_SUB = 2'b01;
    localparam logic [ALUOP_W-1:0] ALU_AND = 2'b10;
    localparam logic [ALUOP_W-1:0] ALU_NOT = 2'b11;

    typedef enum logic [3:0] {
        S_IF    = 4'd0,
        S_ID    = 4'd1,
        S_POPA  = 4'd2,
        S_POPB  = 4'd3,
        S_EXEC  = 4'd4,
        S_PUSHR = 4'd5,
        S_MRD   = 4'd6,
        S_PUSHM = 4'd7,
        S_MWR   = 4'd8,
        S_JMP   = 4'd9,
        S_TOSZ  = 4'd10,
        S_JZX   = 4'd11
    } state_t;

    // Control bundle bit positions; ALUOp occupies ALUOP_W bits starting at C_ALUOP.
    localparam int C_PC_WRITE      = 0;
    localparam int C_PC_WRITE_COND = 1;
    localparam int C_PC_SRC        = 2;
    localparam int C_IORD          = 3;
    localparam int C_MEM_READ      = 4;
    localparam int C_MEM_WRITE     = 5;
    localparam int C_IR_WRITE      = 6;
    localparam int C_MTOS          = 7;
    localparam int C_LDA           = 8;
    localparam int C_LDB           = 9;
    localparam int C_SRCA          = 10;
    localparam int C_SRCB          = 11;
    localparam int C_PUSH          = 12;
    localparam int C_POP           = 13;
    localparam int C_TOS           = 14;
    localparam int C_ALUOP         = 15;
    localparam int C_DONE          = C_ALUOP + ALUOP_W;
    localparam int CTRL_W          = C_DONE + 1;

endpackage

// File: rtl/stack_ctrl_decode.sv
// Moore output decode: state -> control bundle. Reset forces the whole bundle
// low combinationally so the datapath sees no strobes while rst is held.
module stack_ctrl_decode
    import stack_ctrl_pkg::*;
(
    input  logic               rst,
    input  state_t             state,
    input  logic [ALUOP_W-1:0] alu_fn,
    output logic [CTRL_W-1:0]  ctrl
);

    always_comb begin
        ctrl = '0;
        if (!rst) begin
            case (state)
                S_IF: begin
                    ctrl[C_MEM_READ]            = 1'b1;
                    ctrl[C_IR_WRITE]            = 1'b1;
                    ctrl[C_SRCA]                = 1'b1;
                    ctrl[C_SRCB]                = 1'b1;
                    ctrl[C_ALUOP +: ALUOP_W]    = ALU_ADD;
                    ctrl[C_PC_WRITE]            = 1'b1;
                end
                S_ID: ctrl = '0;
                S_POPA: begin
                    ctrl[C_POP] = 1'b1;
                    ctrl[C_LDA] = 1'b1;
                end
                S_POPB: begin
                    ctrl[C_POP] = 1'b1;
                    ctrl[C_LDB] = 1'b1;
                end
                S_EXEC: ctrl[C_ALUOP +: ALUOP_W] = alu_fn;
                S_PUSHR: begin
                    ctrl[C_PUSH] = 1'b1;
                    ctrl[C_DONE] = 1'b1;
                end
                S_MRD: begin
                    ctrl[C_IORD]     = 1'b1;
                    ctrl[C_MEM_READ] = 1'b1;
                end
                S_PUSHM: begin
                    ctrl[C_PUSH] = 1'b1;
                    ctrl[C_MTOS] = 1'b1;
                    ctrl[C_DONE] = 1'b1;
                end
                S_MWR: begin
                    ctrl[C_IORD]      = 1'b1;
                    ctrl[C_MEM_WRITE] = 1'b1;
                    ctrl[C_DONE]      = 1'b1;
                end
                S_JMP: begin
                    ctrl[C_PC_SRC]   = 1'b1;
                    ctrl[C_PC_WRITE] = 1'b1;
                    ctrl[C_DONE]     = 1'b1;
                end
                S_TOSZ: ctrl[C_TOS] = 1'b1;
                S_JZX: begin
                    ctrl[C_PC_SRC]        = 1'b1;
                    ctrl[C_PC_WRITE_COND] = 1'b1;
                    ctrl[C_DONE]          = 1'b1;
                end
                default: ctrl = '0;
            endcase
        end
    end

endmodule

// File: rtl/stack_controller.sv
// Multicycle control FSM for the 8-bit stack-machine datapath.
//
//   state | meaning
//   IF    | fetch instruction, PC <- PC + 1 through the ALU
//   ID    | decode; opcode captured for the rest of the instruction
//   POPA  | pop top of stack into A
//   POPB  | pop top of stack into B
//   EXEC  | ALU operates on A/B, result into ALU reg
//   PUSHR | push ALU reg
//   MRD   | read memory at IR address into MDR
//   PUSHM | push MDR
//   MWR   | write A to memory at IR address
//   JMP   | PC <- IR address
//   TOSZ  | present top of stack to the zero detector
//   JZX   | PC <- IR address when zero flag set
module stack_controller
    import stack_ctrl_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic [OPCODE_W-1:0] opcode,
    output logic                pcWrite,
    output logic                pcWriteCond,
    output logic                pcSrc,
    output logic                IorD,
    output logic                memRead,
    output logic                memWrite,
    output logic                IRWrite,
    output logic                MtoS,
    output logic                ldA,
    output logic                ldB,
    output logic                srcA,
    output logic                srcB,
    output logic                push,
    output logic                pop,
    output logic                tos,
    output logic [ALUOP_W-1:0]  ALUOp,
    output logic                instr_done
);

    state_t              state;
    logic [OPCODE_W-1:0] op_q;
    logic [CTRL_W-1:0]   ctrl;

    // Opcode is held locally from ID onward so later states do not depend on IR stability.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= S_IF;
            op_q  <= '0;
        end else begin
            case (state)
                S_IF:  state <= S_ID;
                S_ID: begin
                    op_q <= opcode;
                    case (opcode)
                        OP_PUSH: state <= S_MRD;
                        OP_JMP:  state <= S_JMP;
                        OP_JZ:   state <= S_TOSZ;
                        default: state <= S_POPA;
                    endcase
                end
                S_POPA: begin
                    case (op_q)
                        OP_NOT:  state <= S_EXEC;
                        OP_POP:  state <= S_MWR;
                        default: state <= S_POPB;
                    endcase
                end
                S_POPB:  state <= S_EXEC;
                S_EXEC:  state <= S_PUSHR;
                S_MRD:   state <= S_PUSHM;
                S_TOSZ:  state <= S_JZX;
                default: state <= S_IF;
            endcase
        end
    end

    stack_ctrl_decode u_decode (
        .rst    (rst),
        .state  (state),
        .alu_fn (op_q[ALUOP_W-1:0]),
        .ctrl   (ctrl)
    );

    assign pcWrite     = ctrl[C_PC_WRITE];
    assign pcWriteCond = ctrl[C_PC_WRITE_COND];
    assign pcSrc       = ctrl[C_PC_SRC];
    assign IorD        = ctrl[C_IORD];
    assign memRead     = ctrl[C_MEM_READ];
    assign memWrite    = ctrl[C_MEM_WRITE];
    assign IRWrite     = ctrl[C_IR_WRITE];
    assign MtoS        = ctrl[C_MTOS];
    assign ldA         = ctrl[C_LDA];
    assign ldB         = ctrl[C_LDB];
    assign srcA        = ctrl[C_SRCA];
    assign srcB        = ctrl[C_SRCB];
    assign push        = ctrl[C_PUSH];
    assign pop         = ctrl[C_POP];
    assign tos         = ctrl[C_TOS];
    assign ALUOp       = ctrl[C_ALUOP +: ALUOP_W];
    assign instr_done  = ctrl[C_DONE];

endmodule

// File: tb/tb_stack_controller.sv
// Bench for stack_controller: per-instruction micro-op model compared cycle by cycle,
// directed reset/opcode cases followed by a random opcode stream.
module tb_stack_controller;

    typedef struct packed {
        logic       pcWrite;
        logic       pcWriteCond;
        logic       pcSrc;
        logic       IorD;
        logic       memRead;
        logic       memWrite;
        logic       IRWrite;
        logic       MtoS;
        logic       ldA;
        logic       ldB;
        logic       srcA;
        logic       srcB;
        logic       push;
        logic       pop;
        logic       tos;
        logic [1:0] ALUOp;
        logic       instr_done;
    } ctrl_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [2:0] opcode;
    logic       pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS;
    logic       ldA, ldB, srcA, srcB, push, pop, tos, instr_done;
    logic [1:0] ALUOp;
    ctrl_t      obs;

    int    checks = 0;
    int    errors = 0;
    ctrl_t exp_q[$];
    int    latency[8] = '{6, 6, 6, 5, 4, 4, 3, 4};

    stack_controller dut (
        .clk         (clk),
        .rst         (rst),
        .opcode      (opcode),
        .pcWrite     (pcWrite),
        .pcWriteCond (pcWriteCond),
        .pcSrc       (pcSrc),
        .IorD        (IorD),
        .memRead     (memRead),
        .memWrite    (memWrite),
        .IRWrite     (IRWrite),
        .MtoS        (MtoS),
        .ldA         (ldA),
        .ldB         (ldB),
        .srcA        (srcA),
        .srcB        (srcB),
        .push        (push),
        .pop         (pop),
        .tos         (tos),
        .ALUOp       (ALUOp),
        .instr_done  (instr_done)
    );

    assign obs = {pcWrite, pcWriteCond, pcSrc, IorD, memRead, memWrite, IRWrite, MtoS,
                  ldA, ldB, srcA, srcB, push, pop, tos, ALUOp, instr_done};

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: time limit reached, observed no finish, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [17:0] o, input logic [17:0] e);
        checks++;
        assert (o === e) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, o, e);
        end
    endtask

    // Micro-operations of the instruction set, one per cycle.
    function automatic ctrl_t mo_fetch();
        ctrl_t c = '0;
        c.memRead = 1'b1; c.IRWrite = 1'b1; c.srcA = 1'b1; c.srcB = 1'b1; c.pcWrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t mo_pop(input bit into_b);
        ctrl_t c = '0;
        c.pop = 1'b1;
        if (into_b) c.ldB = 1'b1; else c.ldA = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t mo_alu(input logic [2:0] op);
        ctrl_t c = '0;
        case (op)
            3'b000:  c.ALUOp = 2'b00;
            3'b001:  c.ALUOp = 2'b01;
            3'b010:  c.ALUOp = 2'b10;
            default: c.ALUOp = 2'b11;
        endcase
        return c;
    endfunction

    function automatic ctrl_t mo_push(input bit from_mdr);
        ctrl_t c = '0;
        c.push = 1'b1; c.MtoS = from_mdr; c.instr_done = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t mo_mem(input bit write);
        ctrl_t c = '0;
        c.IorD = 1'b1;
        if (write) begin c.memWrite = 1'b1; c.instr_done = 1'b1; end
        else c.memRead = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t mo_jump(input bit cond);
        ctrl_t c = '0;
        c.pcSrc = 1'b1; c.instr_done = 1'b1;
        if (cond) c.pcWriteCond = 1'b1; else c.pcWrite = 1'b1;
        return c;
    endfunction

    function automatic ctrl_t mo_tos();
        ctrl_t c = '0;
        c.tos = 1'b1;
        return c;
    endfunction

    task automatic plan(input logic [2:0] op);
        exp_q.delete();
        exp_q.push_back(mo_fetch());
        exp_q.push_back(ctrl_t'('0));
        case (op)
            3'b000, 3'b001, 3'b010: begin
                exp_q.push_back(mo_pop(1'b0));
                exp_q.push_back(mo_pop(1'b1));
                exp_q.push_back(mo_alu(op));
                exp_q.push_back(mo_push(1'b0));
            end
            3'b011: begin
                exp_q.push_back(mo_pop(1'b0));
                exp_q.push_back(mo_alu(op));
                exp_q.push_back(mo_push(1'b0));
            end
            3'b100: begin
                exp_q.push_back(mo_mem(1'b0));
                exp_q.push_back(mo_push(1'b1));
            end
            3'b101: begin
                exp_q.push_back(mo_pop(1'b0));
                exp_q.push_back(mo_mem(1'b1));
            end
            3'b110: exp_q.push_back(mo_jump(1'b0));
            default: begin
                exp_q.push_back(mo_tos());
                exp_q.push_back(mo_jump(1'b1));
            end
        endcase
    endtask

    // Entered with the DUT in IF; n = 0 runs the whole instruction, else only n cycles.
    task automatic run_instr(input logic [2:0] op, input int n, input string tag);
        int done_cnt = 0;
        int done_at  = 0;
        int len;
        plan(op);
        len = (n == 0) ? exp_q.size() : n;
        for (int k = 0; k < len; k++) begin
            #1;
            if (k == 0) opcode = op;
            check($sformatf("%s op%0d cyc%0d", tag, op, k + 1), obs, exp_q[k]);
            check($sformatf("%s push_and_pop", tag), {17'b0, push & pop}, 18'b0);
            check($sformatf("%s rd_and_wr", tag), {17'b0, memRead & memWrite}, 18'b0);
            if (instr_done) begin
                done_cnt++;
                done_at = k + 1;
            end
            @(posedge clk);
        end
        if (n == 0) begin
            check($sformatf("%s op%0d done_count", tag, op), 18'(done_cnt), 18'd1);
            check($sformatf("%s op%0d latency", tag, op), 18'(done_at), 18'(latency[op]));
        end
    endtask

    initial begin
        rst    = 1'b1;
        opcode = 3'b000;
        repeat (2) @(posedge clk);
        #1;
        check("reset_initial", obs, 18'b0);
        rst = 1'b0;

        run_instr(3'b000, 0, "add");

        // Stop mid-ADD in EXEC, then reset for 3 cycles.
        run_instr(3'b000, 4, "add_partial");
        #1;
        check("exec_before_reset", obs, mo_alu(3'b000));
        rst = 1'b1;
        #1;
        check("reset_in_exec", obs, 18'b0);
        for (int i = 0; i < 3; i++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", i), obs, 18'b0);
        end
        rst = 1'b0;

        run_instr(3'b000, 0, "after_reset");
        run_instr(3'b011, 0, "not");
        run_instr(3'b100, 0, "push");
        run_instr(3'b101, 0, "pop");
        run_instr(3'b110, 0, "jmp");
        run_instr(3'b111, 0, "jz");
        run_instr(3'b001, 0, "sub");
        run_instr(3'b010, 0, "and");

        for (int i = 0; i < 40; i++)
            run_instr(3'($urandom_range(0, 7)), 0, "rand");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
